c1_bus_arbiter: RTL and testbench

Round-robin arbiter and bus sequencer that shares the Cache's CPU-side bus (C1/A1/D1) between two requesters. Each requester presents a whole request in one parallel word: command, full cache address and 32-bit write data. The block wins the bus for one requester and runs the two-phase command/address transfer, turns the bus around, and waits for `C1_RESPONSE`. It collects read data in 16-bit beats and returns a one-cycle completion to that requester. It sits between the CPU-side masters and the Cache's A1/D1/C1 pins. The tri-state bus is split into out/in/output-enable signals; a top-level wrapper does the tri-stating.

---
 rtl/c1_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_c1_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1_bus_arbiter.sv
// ---------------------------------------------------------------------------
// c1_bus_arbiter
//
// Shares the Cache's CPU-side bus (C1/A1/D1) between two requesters.
// Each requester presents one parallel request word: command, full cache
// address and 32-bit write data. The arbiter grants the bus round-robin,
// runs the command/address transfer, turns the bus around, waits for
// C1_RESPONSE, collects read data in 16-bit beats and returns a one-cycle
// completion pulse to the granted requester.
//
// The tri-state bus is split into separate out/in/output-enable signals.
// A wrapper above this block does the actual tri-stating.
//
// Ports
//   CLK                    rising-edge clock
//   RESET                  asynchronous, active-low reset
//   REQn_VALID             request pending, held until REQn_DONE
//   REQn_CMD               C1 command (NOP means no request)
//   REQn_ADDR              cache address, laid out tag|set|offset
//   REQn_WDATA             write data, byte 0 in [7:0]
//   REQn_DONE              one-cycle completion pulse
//   REQn_ERR               timeout flag, meaningful only with REQn_DONE
//   RDATA                  read data, unused bytes are zero
//   C1_OUT/A1_OUT/D1_OUT   values driven towards the cache
//   C1_OE/A1_OE/D1_OE      bus-drive enables
//   C1_IN/D1_IN            C1 and D1 as seen on the bus
//
// The read-data path assumes two D1 beats make up the 32-bit word, so
// DATA_BUS_SIZE is expected to stay at 16.
// ---------------------------------------------------------------------------
module c1_bus_arbiter #(
    parameter int CACHE_TAG_SIZE    = 10,
    parameter int CACHE_SET_SIZE    = 5,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int ADDR1_BUS_SIZE    = 15,
    parameter int DATA_BUS_SIZE     = 16,
    parameter int CTR1_BUS_SIZE     = 3,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                                                     CLK,
    input  logic                                                     RESET,
    input  logic                                                     REQ0_VALID,
    input  logic [CTR1_BUS_SIZE-1:0]                                 REQ0_CMD,
    input  logic [CACHE_TAG_SIZE+CACHE_SET_SIZE+CACHE_OFFSET_SIZE-1:0] REQ0_ADDR,
    input  logic [31:0]                                              REQ0_WDATA,
    input  logic                                                     REQ1_VALID,
    input  logic [CTR1_BUS_SIZE-1:0]                                 REQ1_CMD,
    input  logic [CACHE_TAG_SIZE+CACHE_SET_SIZE+CACHE_OFFSET_SIZE-1:0] REQ1_ADDR,
    input  logic [31:0]                                              REQ1_WDATA,
    output logic                                                     REQ0_DONE,
    output logic                                                     REQ0_ERR,
    output logic                                                     REQ1_DONE,
    output logic                                                     REQ1_ERR,
    output logic [31:0]                                              RDATA,
    output logic [CTR1_BUS_SIZE-1:0]                                 C1_OUT,
    output logic [ADDR1_BUS_SIZE-1:0]                                A1_OUT,
    output logic [DATA_BUS_SIZE-1:0]                                 D1_OUT,
    output logic                                                     C1_OE,
    output logic                                                     A1_OE,
    output logic                                                     D1_OE,
    input  logic [CTR1_BUS_SIZE-1:0]                                 C1_IN,
    input  logic [DATA_BUS_SIZE-1:0]                                 D1_IN
);

    localparam int ADDR_W = CACHE_TAG_SIZE + CACHE_SET_SIZE + CACHE_OFFSET_SIZE;
    localparam int DW     = DATA_BUS_SIZE;
    localparam int CNT_W  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP      = CTR1_BUS_SIZE'(0);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8    = CTR1_BUS_SIZE'(1);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16   = CTR1_BUS_SIZE'(2);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32   = CTR1_BUS_SIZE'(3);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8   = CTR1_BUS_SIZE'(5);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16  = CTR1_BUS_SIZE'(6);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32  = CTR1_BUS_SIZE'(7);
    localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE = CTR1_BUS_SIZE'(7);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_LO,
        S_TURN,
        S_WAIT_RESP,
        S_READ_HI,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic [CTR1_BUS_SIZE-1:0] cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tmo_q, tmo_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          done_q, done_d;
    logic                err_q, err_d;

    logic                elig0, elig1;
    logic                is_read, is_write;
    logic [CNT_W-1:0]    cnt_inc;

    assign elig0    = REQ0_VALID && (REQ0_CMD != C1_NOP);
    assign elig1    = REQ1_VALID && (REQ1_CMD != C1_NOP);
    assign is_read  = cmd_q inside {C1_READ8, C1_READ16, C1_READ32};
    assign is_write = cmd_q inside {C1_WRITE8, C1_WRITE16, C1_WRITE32};
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // State and datapath registers. Reset aborts any transaction at once;
    // because the bus outputs are decoded from state_q, the enables drop
    // as soon as RESET falls.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            rdata_q <= '0;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state, datapath updates and bus drive. The completion pulse is
    // registered out of the DONE state, so it appears in the cycle after
    // DONE, together with the final RDATA value; the next grant can only be
    // taken on the edge that ends the pulse.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        done_d  = 2'b00;
        err_d   = 1'b0;
        C1_OUT  = '0;
        A1_OUT  = '0;
        D1_OUT  = '0;
        C1_OE   = 1'b0;
        A1_OE   = 1'b0;
        D1_OE   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (elig0 || elig1) begin
                    // With both eligible, the one not granted last wins.
                    gnt_d   = (elig0 && elig1) ? ~last_q : elig1;
                    cmd_d   = gnt_d ? REQ1_CMD   : REQ0_CMD;
                    addr_d  = gnt_d ? REQ1_ADDR  : REQ0_ADDR;
                    wdata_d = gnt_d ? REQ1_WDATA : REQ0_WDATA;
                    tmo_d   = 1'b0;
                    state_d = S_CMD;
                end
            end

            S_CMD: begin
                C1_OUT  = cmd_q;
                A1_OUT  = ADDR1_BUS_SIZE'(addr_q[ADDR_W-1:CACHE_OFFSET_SIZE]);
                D1_OUT  = wdata_q[DW-1:0];
                C1_OE   = 1'b1;
                A1_OE   = 1'b1;
                D1_OE   = is_write;
                state_d = S_ADDR_LO;
            end

            S_ADDR_LO: begin
                C1_OUT  = cmd_q;
                A1_OUT  = ADDR1_BUS_SIZE'(addr_q[CACHE_OFFSET_SIZE-1:0]);
                D1_OUT  = wdata_q[2*DW-1:DW];
                C1_OE   = 1'b1;
                A1_OE   = 1'b1;
                D1_OE   = (cmd_q == C1_WRITE32);
                state_d = S_TURN;
            end

            S_TURN: begin
                cnt_d   = '0;
                state_d = S_WAIT_RESP;
            end

            S_WAIT_RESP: begin
                if (C1_IN == C1_RESPONSE) begin
                    if (is_read) begin
                        rdata_d = {{DW{1'b0}}, D1_IN};
                        if (cmd_q == C1_READ8) begin
                            rdata_d[15:8] = 8'h00;
                        end
                    end
                    state_d = (cmd_q == C1_READ32) ? S_READ_HI : S_DONE;
                end else begin
                    // The edge that brings the count up to the limit ends
                    // the wait, so WAIT_RESP never lasts longer than
                    // TIMEOUT_CYCLES cycles.
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LIMIT) begin
                        tmo_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_DONE;
                    end
                end
            end

            S_READ_HI: begin
                rdata_d[2*DW-1:DW] = D1_IN;
                state_d            = S_DONE;
            end

            S_DONE: begin
                done_d  = gnt_q ? 2'b10 : 2'b01;
                err_d   = tmo_q;
                last_d  = gnt_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign REQ0_DONE = done_q[0];
    assign REQ1_DONE = done_q[1];
    assign REQ0_ERR  = done_q[0] & err_q;
    assign REQ1_ERR  = done_q[1] & err_q;
    assign RDATA     = rdata_q;

endmodule

// File: tb/tb_c1_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_c1_bus_arbiter
//
// Directed and randomized bench for c1_bus_arbiter. The bench plays both
// requesters and the cache. A small reference model predicts which
// requester wins each grant, the bus contents in every phase, the cycle in
// which the completion pulse appears and the resulting RDATA value.
// ---------------------------------------------------------------------------
module tb_c1_bus_arbiter;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0_VALID, REQ1_VALID;
    logic [2:0]  REQ0_CMD, REQ1_CMD;
    logic [18:0] REQ0_ADDR, REQ1_ADDR;
    logic [31:0] REQ0_WDATA, REQ1_WDATA;
    logic        REQ0_DONE, REQ0_ERR, REQ1_DONE, REQ1_ERR;
    logic [31:0] RDATA;
    logic [2:0]  C1_OUT;
    logic [14:0] A1_OUT;
    logic [15:0] D1_OUT;
    logic        C1_OE, A1_OE, D1_OE;
    logic [2:0]  C1_IN;
    logic [15:0] D1_IN;

    // Requester-side view kept by the bench
    logic        rq_valid [2];
    logic [2:0]  rq_cmd   [2];
    logic [18:0] rq_addr  [2];
    logic [31:0] rq_wdata [2];

    int          n_cmp      = 0;
    int          n_fail     = 0;
    int          last_grant = 1;
    logic [31:0] exp_rdata  = 32'd0;
    int          w;

    assign REQ0_VALID = rq_valid[0];
    assign REQ0_CMD   = rq_cmd[0];
    assign REQ0_ADDR  = rq_addr[0];
    assign REQ0_WDATA = rq_wdata[0];
    assign REQ1_VALID = rq_valid[1];
    assign REQ1_CMD   = rq_cmd[1];
    assign REQ1_ADDR  = rq_addr[1];
    assign REQ1_WDATA = rq_wdata[1];

    always #5 CLK = ~CLK;

    c1_bus_arbiter #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_CMD   (REQ0_CMD),
        .REQ0_ADDR  (REQ0_ADDR),
        .REQ0_WDATA (REQ0_WDATA),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_CMD   (REQ1_CMD),
        .REQ1_ADDR  (REQ1_ADDR),
        .REQ1_WDATA (REQ1_WDATA),
        .REQ0_DONE  (REQ0_DONE),
        .REQ0_ERR   (REQ0_ERR),
        .REQ1_DONE  (REQ1_DONE),
        .REQ1_ERR   (REQ1_ERR),
        .RDATA      (RDATA),
        .C1_OUT     (C1_OUT),
        .A1_OUT     (A1_OUT),
        .D1_OUT     (D1_OUT),
        .C1_OE      (C1_OE),
        .A1_OE      (A1_OE),
        .D1_OE      (D1_OE),
        .C1_IN      (C1_IN),
        .D1_IN      (D1_IN)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: eligible means VALID with a non-NOP command; on a
    // tie the requester not granted last wins.
    function automatic int pick_winner();
        bit e0, e1;
        e0 = rq_valid[0] && (rq_cmd[0] != 3'd0);
        e1 = rq_valid[1] && (rq_cmd[1] != 3'd0);
        if (e0 && e1) return (last_grant == 1) ? 0 : 1;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic new_request(input int r);
        rq_valid[r] = 1'b1;
        rq_cmd[r]   = 3'($urandom_range(1, 7));
        rq_addr[r]  = 19'($urandom);
        rq_wdata[r] = $urandom;
    endtask

    // Runs one whole transaction for requester wr, which must be the one the
    // arbiter grants at the next rising edge (E0). The cache answers at edge
    // E4+delay, or never when delay >= TO. Cycle n is the cycle E(n)->E(n+1),
    // observed 1 time unit after E(n).
    task automatic serve(input int wr, input int delay, input logic [15:0] lo,
                         input logic [15:0] hi, input bit drop);
        logic [2:0]  cmd;
        logic [18:0] addr;
        logic [31:0] wdata;
        bit          tmo, is_wr;
        int          r_edge, d_cyc;
        logic        my_done, oth_done, my_err;
        cmd    = rq_cmd[wr];
        addr   = rq_addr[wr];
        wdata  = rq_wdata[wr];
        tmo    = (delay >= TO);
        is_wr  = (cmd >= 3'd5);
        r_edge = 4 + delay;
        if (tmo)              d_cyc = 3 + TO + 1;
        else if (cmd == 3'd3) d_cyc = r_edge + 2;
        else                  d_cyc = r_edge + 1;
        if (tmo)               exp_rdata = 32'd0;
        else if (cmd == 3'd1)  exp_rdata = {24'd0, lo[7:0]};
        else if (cmd == 3'd2)  exp_rdata = {16'd0, lo};
        else if (cmd == 3'd3)  exp_rdata = {hi, lo};

        @(posedge CLK); #1;
        check_output("cmd_c1_out", 32'(C1_OUT), 32'(cmd));
        check_output("cmd_a1_out", 32'(A1_OUT), 32'(addr[18:4]));
        check_output("cmd_d1_out", 32'(D1_OUT), 32'(wdata[15:0]));
        check_output("cmd_oe", 32'({C1_OE, A1_OE, D1_OE}), 32'({2'b11, is_wr}));

        @(posedge CLK); #1;
        check_output("alo_c1_out", 32'(C1_OUT), 32'(cmd));
        check_output("alo_a1_out", 32'(A1_OUT), 32'(addr[3:0]));
        check_output("alo_d1_out", 32'(D1_OUT), 32'(wdata[31:16]));
        check_output("alo_oe", 32'({C1_OE, A1_OE, D1_OE}), 32'({2'b11, cmd == 3'd7}));

        @(posedge CLK); #1;
        check_output("turn_oe", 32'({C1_OE, A1_OE, D1_OE}), 32'd0);

        for (int n = 3; n <= d_cyc; n++) begin
            @(posedge CLK); #1;
            if (!tmo && n == r_edge - 1) begin
                C1_IN = 3'd7;
                D1_IN = lo;
            end else if (!tmo && cmd == 3'd3 && n == r_edge) begin
                C1_IN = 3'd0;
                D1_IN = hi;
            end else begin
                C1_IN = 3'($urandom_range(0, 6));
                D1_IN = 16'($urandom);
            end
            my_done  = (wr == 0) ? REQ0_DONE : REQ1_DONE;
            oth_done = (wr == 0) ? REQ1_DONE : REQ0_DONE;
            my_err   = (wr == 0) ? REQ0_ERR  : REQ1_ERR;
            check_output("wait_oe", 32'({C1_OE, A1_OE, D1_OE}), 32'd0);
            check_output("done_granted", 32'(my_done), 32'(n == d_cyc));
            check_output("done_other", 32'(oth_done), 32'd0);
            if (n == d_cyc) begin
                check_output("err_flag", 32'(my_err), 32'(tmo));
                check_output("rdata", RDATA, exp_rdata);
            end
        end
        C1_IN      = 3'd0;
        last_grant = wr;
        if (drop) rq_valid[wr] = 1'b0;
    endtask

    initial begin
        RESET = 1'b0;
        C1_IN = 3'd0;
        D1_IN = 16'd0;
        for (int r = 0; r < 2; r++) begin
            rq_valid[r] = 1'b0;
            rq_cmd[r]   = 3'd0;
            rq_addr[r]  = 19'd0;
            rq_wdata[r] = 32'd0;
        end

        // Reset state
        #1;
        check_output("rst_oe", 32'({C1_OE, A1_OE, D1_OE}), 32'd0);
        check_output("rst_c1_out", 32'(C1_OUT), 32'd0);
        check_output("rst_a1_out", 32'(A1_OUT), 32'd0);
        check_output("rst_d1_out", 32'(D1_OUT), 32'd0);
        check_output("rst_rdata", RDATA, 32'd0);
        check_output("rst_done_err", 32'({REQ0_DONE, REQ1_DONE, REQ0_ERR, REQ1_ERR}), 32'd0);

        // Simultaneous requests from reset, held through four grants:
        // strict alternation 0,1,0,1. The first READ8 also checks byte masking.
        rq_valid[0] = 1'b1; rq_cmd[0] = 3'd1; rq_addr[0] = 19'h12345; rq_wdata[0] = 32'h01010101;
        rq_valid[1] = 1'b1; rq_cmd[1] = 3'd2; rq_addr[1] = 19'h5A5A5; rq_wdata[1] = 32'h02020202;
        repeat (2) @(posedge CLK);
        @(negedge CLK) RESET = 1'b1;
        $display("[TB] simultaneous requests");
        for (int k = 0; k < 4; k++) begin
            w = pick_winner();
            serve(w, 0, (k == 0) ? 16'hAB12 : 16'(16'h1000 + k), 16'h0000, 1'b0);
        end
        rq_valid[0] = 1'b0;
        rq_valid[1] = 1'b0;

        // READ32 from requester 0, tag=1 set=2 offset=3, response at E5
        $display("[TB] read32");
        rq_valid[0] = 1'b1; rq_cmd[0] = 3'd3; rq_addr[0] = {10'd1, 5'd2, 4'd3};
        w = pick_winner();
        serve(w, 1, 16'h2211, 16'h4433, 1'b1);

        // WRITE32 from requester 1; RDATA must keep the READ32 value
        $display("[TB] write32");
        rq_valid[1] = 1'b1; rq_cmd[1] = 3'd7; rq_addr[1] = 19'h7FFFF; rq_wdata[1] = 32'hDEADBEEF;
        w = pick_winner();
        serve(w, 2, 16'hFFFF, 16'h0000, 1'b1);

        // Requester 0 valid with NOP is not eligible; requester 1 wins
        $display("[TB] nop not eligible");
        rq_valid[0] = 1'b1; rq_cmd[0] = 3'd0;
        rq_valid[1] = 1'b1; rq_cmd[1] = 3'd2; rq_addr[1] = 19'h00F0F;
        w = pick_winner();
        serve(w, 0, 16'hC0DE, 16'h0000, 1'b1);
        rq_valid[0] = 1'b0;

        // INVALIDATE_LINE with no response: timeout completion
        $display("[TB] invalidate timeout");
        rq_valid[0] = 1'b1; rq_cmd[0] = 3'd4; rq_addr[0] = 19'h2AAAA;
        w = pick_winner();
        serve(w, TO, 16'h0000, 16'h0000, 1'b1);

        // Reset during ADDR_LO
        $display("[TB] reset mid-transaction");
        rq_valid[0] = 1'b1; rq_cmd[0] = 3'd2; rq_addr[0] = 19'h13579;
        @(posedge CLK); #1;
        check_output("pre_rst_cmd_oe", 32'(C1_OE), 32'd1);
        @(posedge CLK); #1;
        check_output("pre_rst_alo_oe", 32'(A1_OE), 32'd1);
        #2 RESET = 1'b0;
        #1;
        check_output("mid_rst_oe", 32'({C1_OE, A1_OE, D1_OE}), 32'd0);
        check_output("mid_rst_c1_out", 32'(C1_OUT), 32'd0);
        rq_valid[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            check_output("mid_rst_no_done", 32'({REQ0_DONE, REQ1_DONE}), 32'd0);
        end
        @(negedge CLK) RESET = 1'b1;
        last_grant = 1;
        exp_rdata  = 32'd0;
        check_output("post_rst_rdata", RDATA, 32'd0);
        rq_valid[0] = 1'b1; rq_cmd[0] = 3'd2; rq_addr[0] = 19'h24680;
        w = pick_winner();
        serve(w, 0, 16'h7E57, 16'h0000, 1'b1);

        // Randomized traffic; delays of TO and above produce timeouts
        $display("[TB] random traffic");
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!rq_valid[r] && ($urandom_range(0, 1) == 1)) new_request(r);
            end
            if (!rq_valid[0] && !rq_valid[1]) new_request(int'($urandom_range(0, 1)));
            w = pick_winner();
            serve(w, int'($urandom_range(0, TO + 1)), 16'($urandom), 16'($urandom), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
